// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage: PC generator, one-deep in-flight IMEM request and a prefetch queue.
// Optional macro IF_STAGE_PERF_CNT_EN adds saturating FetchCount/FlushCount outputs.
module if_stage_prefetch #(
   parameter int unsigned      PC_W        = 32,
   parameter int unsigned      IMEM_AW     = 8,
   parameter int unsigned      QUEUE_DEPTH = 4,
   parameter logic [PC_W-1:0]  RESET_PC    = '0
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               Branch,
   input  logic               Jump,
   input  logic [31:0]        BranchOffset,
   input  logic [25:0]        JumpAddress,
   input  logic               Stall,
   output logic               ImemReq,
   output logic [IMEM_AW-1:0] ImemAddr,
   input  logic [31:0]        ImemData,
   output logic [31:0]        Inst,
   output logic [PC_W-1:0]    InstPC,
   output logic               InstValid
`ifdef IF_STAGE_PERF_CNT_EN
   ,
   output logic [31:0]        FetchCount,
   output logic [15:0]        FlushCount
`endif
);

   localparam int unsigned PW = $clog2(QUEUE_DEPTH);

   logic [31:0]     inst_q [QUEUE_DEPTH];
   logic [PC_W-1:0] pc_q   [QUEUE_DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [PW:0]     count;
   logic [PW+1:0]   occ;
   logic            inflight;
   logic [PC_W-1:0] inflight_pc;
   logic [PC_W-1:0] fetch_pc, last_pc;
   logic [PC_W-1:0] base, branch_tgt, jump_tgt, target;
   logic [PC_W+31:0] off_ext;
   logic            redirect, issue, push, pop;
   logic            unused_off;

   assign redirect  = Branch | Jump;
   assign occ       = {1'b0, count} + {{(PW+1){1'b0}}, inflight};
   assign issue     = ~redirect & (occ < (PW+2)'(QUEUE_DEPTH));
   assign push      = inflight & ~redirect;
   assign InstValid = (count != '0);
   assign pop       = InstValid & ~Stall & ~redirect;

   // Reset gates only the output strobe; internal state is already held by the async reset.
   assign ImemReq   = issue & Reset_n;
   assign ImemAddr  = fetch_pc[IMEM_AW+1:2];
   assign Inst      = InstValid ? inst_q[rd_ptr] : '0;
   assign InstPC    = InstValid ? pc_q[rd_ptr]   : '0;

   always_comb begin
      base       = last_pc + PC_W'(4);
      off_ext    = {{PC_W{BranchOffset[31]}}, BranchOffset};
      branch_tgt = base + {off_ext[PC_W-3:0], 2'b00};
      jump_tgt   = base;
      jump_tgt[27:0] = {JumpAddress, 2'b00};
      target     = Jump ? jump_tgt : branch_tgt;
   end

   assign unused_off = ^off_ext[PC_W+31:PC_W-2];

   always_ff @(posedge Clk) begin
      if (push) begin
         inst_q[wr_ptr] <= ImemData;
         pc_q[wr_ptr]   <= inflight_pc;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fetch_pc    <= RESET_PC;
         last_pc     <= RESET_PC - PC_W'(4);
         inflight    <= 1'b0;
         inflight_pc <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= fetch_pc;
         end
         if (redirect) begin
            fetch_pc <= target;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
         end else begin
            if (issue) begin
               fetch_pc <= fetch_pc + PC_W'(4);
            end
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr  <= rd_ptr + PW'(1);
               last_pc <= pc_q[rd_ptr];
            end
            case ({push, pop})
               2'b10:   count <= count + (PW+1)'(1);
               2'b01:   count <= count - (PW+1)'(1);
               default: count <= count;
            endcase
         end
      end
   end

`ifdef IF_STAGE_PERF_CNT_EN
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         FetchCount <= '0;
         FlushCount <= '0;
      end else begin
         if (issue && (FetchCount != '1)) begin
            FetchCount <= FetchCount + 32'd1;
         end
         // Only flushes that actually discard a queued or in-flight word are counted.
         if (redirect && ((count != '0) || inflight) && (FlushCount != '1)) begin
            FlushCount <= FlushCount + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Self-checking bench for if_stage_prefetch against a queue-based reference model.
// Build with IF_STAGE_PERF_CNT_EN defined to also check the performance counters.
module tb_if_stage_prefetch;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        Branch = 1'b0, Jump = 1'b0, Stall = 1'b0;
   logic [31:0] BranchOffset = '0;
   logic [25:0] JumpAddress = '0;
   logic [31:0] ImemData = '0;
   logic        ImemReq, InstValid;
   logic [7:0]  ImemAddr;
   logic [31:0] Inst, InstPC;
`ifdef IF_STAGE_PERF_CNT_EN
   logic [31:0] FetchCount;
   logic [15:0] FlushCount;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] mq[$];
   logic [31:0] mfetch, mlast, minf_pc;
   bit          minf;
   int unsigned mfetch_cnt, mflush_cnt;

   if_stage_prefetch #(.PC_W(32), .IMEM_AW(8), .QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Branch(Branch), .Jump(Jump),
      .BranchOffset(BranchOffset), .JumpAddress(JumpAddress), .Stall(Stall),
      .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemData(ImemData),
      .Inst(Inst), .InstPC(InstPC), .InstValid(InstValid)
`ifdef IF_STAGE_PERF_CNT_EN
      , .FetchCount(FetchCount), .FlushCount(FlushCount)
`endif
   );

   always #5 Clk = ~Clk;

   function automatic logic [31:0] rom(input logic [7:0] a);
      return {a, ~a, a ^ 8'h5A, 8'hC3};
   endfunction

   // Synchronous memory: data for the requested word one cycle later, garbage otherwise.
   always @(posedge Clk) begin
      ImemData <= ImemReq ? rom(ImemAddr) : $urandom();
   end

   function automatic bit exp_req();
      return Reset_n && !(Branch || Jump) && ((mq.size() + int'(minf)) < 4);
   endfunction

   function automatic logic [31:0] head_pc();
      return (mq.size() > 0) ? mq[0] : 32'h0;
   endfunction

   function automatic logic [31:0] head_inst();
      logic [31:0] h;
      h = head_pc();
      return rom(h[9:2]);
   endfunction

   function automatic logic [7:0] exp_addr();
      logic [31:0] f;
      f = mfetch;
      return f[9:2];
   endfunction

   task automatic model_reset();
      mq.delete();
      mfetch = 32'h0;
      mlast = 32'hFFFF_FFFC;
      minf = 0;
      minf_pc = 32'h0;
      mfetch_cnt = 0;
      mflush_cnt = 0;
   endtask

   // One clock edge; the model applies the fetch rules to the inputs present at the edge.
   task automatic tick();
      bit req;
      @(posedge Clk);
      req = exp_req();
      if (req) mfetch_cnt++;
      if (Branch || Jump) begin
         if (mq.size() > 0 || minf) mflush_cnt++;
         if (Jump) mfetch = ((mlast + 32'd4) & 32'hF000_0000) | {4'h0, JumpAddress, 2'b00};
         else      mfetch = mlast + 32'd4 + (BranchOffset << 2);
         mq.delete();
         minf = 0;
      end else begin
         if (mq.size() > 0 && !Stall) mlast = mq.pop_front();
         if (minf) mq.push_back(minf_pc);
         if (req) begin
            minf_pc = mfetch;
            mfetch = mfetch + 32'd4;
         end
         minf = req;
      end
      #1;
   endtask

   task automatic do_reset();
      Reset_n = 1'b0; Branch = 0; Jump = 0; Stall = 0;
      model_reset();
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      #1;
      tick();
   endtask

   task automatic run_until_last(input logic [31:0] pc);
      int n;
      n = 0;
      Stall = 0; Branch = 0; Jump = 0;
      while (mlast !== pc && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (mlast !== pc) begin
         errors++;
         $display("FAIL run_until_last timeout last=%h required=%h", mlast, pc);
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      checks += 4;
      if (InstValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", InstValid); end
      if (ImemReq !== 1'b0)   begin errors++; $display("FAIL reset_req got %b exp 0", ImemReq); end
      if (Inst !== 32'h0)     begin errors++; $display("FAIL reset_inst got %h exp 0", Inst); end
      if (InstPC !== 32'h0)   begin errors++; $display("FAIL reset_pc got %h exp 0", InstPC); end
`ifdef IF_STAGE_PERF_CNT_EN
      checks++;
      if (FetchCount !== 32'h0 || FlushCount !== 16'h0) begin
         errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", FetchCount, FlushCount);
      end
`endif
      Reset_n = 1'b1;
      #1;
      checks += 2;
      if (ImemReq !== 1'b1)  begin errors++; $display("FAIL release_req got %b exp 1", ImemReq); end
      if (ImemAddr !== 8'h0) begin errors++; $display("FAIL release_addr got %h exp 0", ImemAddr); end
      tick();
   endtask

   task automatic test_stream();
      int first;
      first = -1;
      for (int k = 1; k <= 16; k++) begin
         Stall = 0;
         @(negedge Clk);
         if (first < 0 && InstValid === 1'b1) first = k;
         checks += 2;
         if (InstValid !== (mq.size() > 0)) begin
            errors++; $display("FAIL stream_valid cyc %0d got %b exp %b", k, InstValid, mq.size() > 0);
         end
         if (ImemReq !== exp_req()) begin
            errors++; $display("FAIL stream_req cyc %0d got %b exp %b", k, ImemReq, exp_req());
         end
         if (k >= 2) begin
            checks += 2;
            if (InstPC !== 32'(4 * (k - 2))) begin
               errors++; $display("FAIL stream_pc cyc %0d got %h exp %h", k, InstPC, 32'(4 * (k - 2)));
            end
            if (Inst !== head_inst()) begin
               errors++; $display("FAIL stream_inst cyc %0d got %h exp %h", k, Inst, head_inst());
            end
         end
         tick();
      end
      checks++;
      if (first !== 2) begin errors++; $display("FAIL first_valid cycle got %0d exp 2", first); end
   endtask

   task automatic test_stall();
      logic [31:0] held;
      held = head_pc();
      for (int k = 0; k < 10; k++) begin
         Stall = 1;
         @(negedge Clk);
         checks += 3;
         if (ImemReq !== exp_req()) begin
            errors++; $display("FAIL stall_req cyc %0d got %b exp %b", k, ImemReq, exp_req());
         end
         if (InstPC !== held) begin
            errors++; $display("FAIL stall_hold_pc cyc %0d got %h exp %h", k, InstPC, held);
         end
         if (Inst !== rom(held[9:2])) begin
            errors++; $display("FAIL stall_hold_inst cyc %0d got %h exp %h", k, Inst, rom(held[9:2]));
         end
         if (k == 9) begin
            checks++;
            if (ImemReq !== 1'b0) begin errors++; $display("FAIL stall_full_req got %b exp 0", ImemReq); end
         end
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         Stall = 0;
         @(negedge Clk);
         checks += 3;
         if (InstValid !== 1'b1) begin errors++; $display("FAIL unstall_valid cyc %0d got %b exp 1", i, InstValid); end
         if (InstPC !== held + 32'(4 * i)) begin
            errors++; $display("FAIL unstall_pc cyc %0d got %h exp %h", i, InstPC, held + 32'(4 * i));
         end
         if (Inst !== head_inst()) begin
            errors++; $display("FAIL unstall_inst cyc %0d got %h exp %h", i, Inst, head_inst());
         end
         tick();
      end
   endtask

   task automatic test_branch();
      do_reset();
      run_until_last(32'h10);
      Branch = 1; BranchOffset = 32'hFFFF_FFFE;
      @(negedge Clk);
      checks++;
      if (ImemReq !== 1'b0) begin errors++; $display("FAIL branch_cycle_req got %b exp 0", ImemReq); end
      tick();
      Branch = 0; BranchOffset = '0;
      @(negedge Clk);
      checks += 3;
      if (ImemAddr !== 8'h3)  begin errors++; $display("FAIL branch_addr got %h exp 03", ImemAddr); end
      if (ImemReq !== 1'b1)   begin errors++; $display("FAIL branch_req got %b exp 1", ImemReq); end
      if (InstValid !== 1'b0) begin errors++; $display("FAIL branch_gap1 got %b exp 0", InstValid); end
      tick();
      @(negedge Clk);
      checks++;
      if (InstValid !== 1'b0) begin errors++; $display("FAIL branch_gap2 got %b exp 0", InstValid); end
      tick();
      @(negedge Clk);
      checks += 3;
      if (InstValid !== 1'b1)     begin errors++; $display("FAIL branch_resume_valid got %b exp 1", InstValid); end
      if (InstPC !== 32'hC)       begin errors++; $display("FAIL branch_resume_pc got %h exp 0000000c", InstPC); end
      if (Inst !== rom(8'h3))     begin errors++; $display("FAIL branch_resume_inst got %h exp %h", Inst, rom(8'h3)); end
      tick();
   endtask

   task automatic test_jump();
      do_reset();
      run_until_last(32'h20);
      Jump = 1; Branch = 1; JumpAddress = 26'h40; BranchOffset = 32'd7;
      tick();
      Jump = 0; Branch = 0;
      tick();
      tick();
      @(negedge Clk);
      checks += 2;
      if (InstPC !== 32'h100)   begin errors++; $display("FAIL jump_pc got %h exp 00000100", InstPC); end
      if (Inst !== rom(8'h40))  begin errors++; $display("FAIL jump_inst got %h exp %h", Inst, rom(8'h40)); end
      tick();
   endtask

   task automatic test_flush_stall();
      logic [31:0] stale, tgt;
      int n, seen;
`ifdef IF_STAGE_PERF_CNT_EN
      logic [15:0] fc0;
`endif
      do_reset();
      repeat (5) tick();
      n = 0;
      Stall = 1;
      while (!(mq.size() == 3 && minf) && n < 20) begin tick(); n++; end
      checks++;
      if (!(mq.size() == 3 && minf)) begin errors++; $display("FAIL flush_setup timeout size=%0d", mq.size()); end
      stale = minf_pc;
      tgt = mlast + 32'd4 + 32'd400;
`ifdef IF_STAGE_PERF_CNT_EN
      @(negedge Clk);
      fc0 = FlushCount;
`endif
      Branch = 1; BranchOffset = 32'd100;
      tick();
      Branch = 0; Stall = 0;
`ifdef IF_STAGE_PERF_CNT_EN
      @(negedge Clk);
      checks++;
      if (FlushCount !== fc0 + 16'd1) begin
         errors++; $display("FAIL flush_count got %0d exp %0d", FlushCount, fc0 + 16'd1);
      end
`endif
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         if (InstValid === 1'b1) begin
            checks++;
            if (InstPC === stale || InstPC !== tgt + 32'(4 * seen)) begin
               errors++; $display("FAIL flush_stale cyc %0d got %h exp %h", i, InstPC, tgt + 32'(4 * seen));
            end
            seen++;
         end
         tick();
      end
      checks++;
      if (seen != 6) begin errors++; $display("FAIL flush_resume count got %0d exp 6", seen); end
   endtask

   task automatic test_reset_midfetch();
      do_reset();
      Stall = 1;
      repeat (3) tick();
      #2;
      Reset_n = 1'b0;
      #1;
      checks += 2;
      if (InstValid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp 0", InstValid); end
      if (ImemReq !== 1'b0)   begin errors++; $display("FAIL midreset_req got %b exp 0", ImemReq); end
      model_reset();
      Stall = 0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      #1;
      checks++;
      if (ImemAddr !== 8'h0) begin errors++; $display("FAIL midreset_addr got %h exp 00", ImemAddr); end
      tick();
      tick();
      @(negedge Clk);
      checks += 2;
      if (InstValid !== 1'b1) begin errors++; $display("FAIL midreset_resume_valid got %b exp 1", InstValid); end
      if (InstPC !== 32'h0)   begin errors++; $display("FAIL midreset_resume_pc got %h exp 0", InstPC); end
      tick();
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         Stall = ($urandom_range(0, 2) == 0);
         Jump = ($urandom_range(0, 99) < 3);
         Branch = ($urandom_range(0, 99) < 6);
         BranchOffset = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($signed($urandom_range(0, 64)) - 32);
         JumpAddress = 26'($urandom());
         @(negedge Clk);
         checks += 3;
         if (InstValid !== (mq.size() > 0)) begin
            errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", k, InstValid, mq.size() > 0);
         end
         if (ImemReq !== exp_req()) begin
            errors++; $display("FAIL rand_req cyc %0d got %b exp %b", k, ImemReq, exp_req());
         end
         if (ImemAddr !== exp_addr()) begin
            errors++; $display("FAIL rand_addr cyc %0d got %h exp %h", k, ImemAddr, exp_addr());
         end
         if (mq.size() > 0) begin
            checks += 2;
            if (InstPC !== head_pc()) begin
               errors++; $display("FAIL rand_pc cyc %0d got %h exp %h", k, InstPC, head_pc());
            end
            if (Inst !== head_inst()) begin
               errors++; $display("FAIL rand_inst cyc %0d got %h exp %h", k, Inst, head_inst());
            end
         end
`ifdef IF_STAGE_PERF_CNT_EN
         checks += 2;
         if (FetchCount !== 32'(mfetch_cnt)) begin
            errors++; $display("FAIL rand_fetchcount cyc %0d got %0d exp %0d", k, FetchCount, mfetch_cnt);
         end
         if (FlushCount !== 16'(mflush_cnt)) begin
            errors++; $display("FAIL rand_flushcount cyc %0d got %0d exp %0d", k, FlushCount, mflush_cnt);
         end
`endif
         tick();
      end
      Branch = 0; Jump = 0; Stall = 0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_branch();
      test_jump();
      test_flush_stall();
      test_reset_midfetch();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_stage_prefetch.md
Name: if_stage_prefetch

Overview:
Parametrised instruction-fetch stage with a PC generator, a synchronous instruction-memory request port and a QUEUE_DEPTH-entry prefetch queue feeding decode.
- Keeps fetching ahead while decode stalls.
- Resolves branch/jump redirects by flushing queued and in-flight words.
- Sits between the instruction memory and the ID stage.

Parameters:
PC_W, 32, program-counter width in bits (≥ 28).
IMEM_AW, 8, instruction-memory word-address width (2^IMEM_AW words).
QUEUE_DEPTH, 4, prefetch-queue entries (power of two, ≥ 2).
RESET_PC, 0, PC of the first fetched instruction (word aligned).

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous active-low reset
Branch  input  1  taken branch, resolved for the last consumed instruction
Jump  input  1  jump, resolved for the last consumed instruction
BranchOffset  input  32  signed word offset
JumpAddress  input  26  jump target field
Stall  input  1  decode cannot accept this cycle
ImemReq  output  1  memory read strobe
ImemAddr  output  IMEM_AW  word address = FetchPC[IMEM_AW+1:2]
ImemData  input  32  read data, valid exactly one cycle after ImemReq
Inst  output  32  queue-head instruction
InstPC  output  PC_W  PC of Inst
InstValid  output  1  queue non-empty

Behaviour:
- Reset (async, Reset_n=0):
  - FetchPC=RESET_PC, LastPC=RESET_PC-4.
  - Queue empty; in-flight flag cleared.
  - ImemReq=0, InstValid=0, Inst=0, InstPC=0.
- Request rule:
  - ImemReq=1 when (count + inflight) < QUEUE_DEPTH and no redirect this cycle.
  - On each issue, FetchPC += 4 (wraps modulo 2^PC_W).
  - Request PC is held in a 1-deep in-flight register.
- Response: the cycle after ImemReq, {ImemData, request PC} is pushed at the queue tail, unless it was killed by a redirect.
- Consume:
  - When InstValid && !Stall, the head pops at the clock edge and LastPC <= InstPC.
  - Push and pop in the same cycle: count unchanged.
  - Pop on empty never occurs (InstValid=0).
- Redirect (Branch|Jump at a clock edge):
  - Base = LastPC + 4.
  - Branch target = Base + (BranchOffset << 2), truncated to PC_W.
  - Jump target = {Base[PC_W-1:28], JumpAddress, 2'b00}.
  - Jump has priority over Branch if both are asserted.
  - Effects:
    - Queue cleared.
    - Pending in-flight response discarded.
    - FetchPC <= target.
    - ImemReq forced 0 during the redirect cycle.
    - The first target fetch issues the next cycle.
  - The redirect overrides Stall and any concurrent pop; the popped head is not recorded in LastPC.
- Latency:
  - First valid Inst appears 2 cycles after reset release (request, then response push).
  - Redirect-to-InstValid is 3 cycles (redirect, request, push).
- Full queue:
  - Issue stops when count + inflight = QUEUE_DEPTH.
  - No entry is ever dropped or overwritten.
- Reset mid-fetch: an outstanding response is ignored; the queue restarts empty.
- Pointers: read/write pointers are log2(QUEUE_DEPTH) bits and wrap naturally; count is log2(QUEUE_DEPTH)+1 bits.

Optional Feature:
IF_STAGE_PERF_CNT_EN:
- When defined, adds two outputs:
  - FetchCount (32, increments per ImemReq).
  - FlushCount (16, increments per redirect that discards ≥1 queued or in-flight word).
- Both counters are saturating and reset to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, Stall=0, ImemData=addr-indexed ROM -> InstPC sequence 0x0,0x4,0x8,...; first InstValid at cycle 2; one instruction per cycle thereafter.
- Stall=1 for 10 cycles from cycle 3 -> ImemReq stops once 4 entries are held; Inst/InstPC hold steady; release yields in-order 0x4..0x10 with no gaps or drops.
- Consume PC 0x10, then Branch=1, BranchOffset=-2 -> queue flushed; next ImemAddr=0x3 (PC 0xC); InstValid low 2 cycles; Inst resumes at InstPC 0xC.
- Last consumed PC 0x20, Jump=1 and Branch=1, JumpAddress=0x40 -> Jump wins; next InstPC=0x100.
- Redirect while Stall=1 with full queue and pending response -> stale word never appears on Inst; FlushCount (feature on) increments by 1.
- Assert Reset_n=0 mid-cycle with queue half full -> InstValid, ImemReq drop immediately; after release, fetch restarts at RESET_PC.
